// File: rtl/b2bcd_pkg.sv
// Shared encodings and constants for the sequential binary-to-BCD converter.
package b2bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Digits strictly above ADJ_THRESH get ADJ_OFFSET added before each shift.
  localparam logic [3:0] ADJ_THRESH = 4'd4;
  localparam logic [3:0] ADJ_OFFSET = 4'd3;

endpackage

// File: rtl/b2bcd_digit_adj.sv
// Double-dabble digit correction: one BCD digit in, add-3-if-above-4 digit out.
module b2bcd_digit_adj
  import b2bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // 4-bit add wraps mod 16; legal digits 5..9 land on 8..12.
  always_comb begin
    digit_o = (digit_i > ADJ_THRESH) ? digit_i + ADJ_OFFSET : digit_i;
  end

endmodule

// File: rtl/b2bcd_seq_ctrl.sv
// Iterative valid/ready binary-to-BCD converter, one operand bit per clock.
module b2bcd_seq_ctrl
  import b2bcd_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     Binary_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIGIT*4-1:0]   BCD_code,
  output logic                 overflow,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned AccW = DIGIT * 4;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [AccW-1:0] acc_q, acc_d, acc_adj;
  logic            ovf_q, ovf_d;

  for (genvar g = 0; g < DIGIT; g++) begin : gen_adj
    b2bcd_digit_adj u_adj (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (acc_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == CntW'(1)) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q == ST_SHIFT);
    out_valid = (state_q == ST_DONE);
  end

  // Shift {acc, op} left; whatever falls off the accumulator top is a lost 10^DIGIT.
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (state_q == ST_IDLE && in_valid) begin
      cnt_d = CntW'(WIDTH);
      op_d  = Binary_code;
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      cnt_d = cnt_q - CntW'(1);
      op_d  = {op_q[WIDTH-2:0], 1'b0};
      acc_d = {acc_adj[AccW-2:0], op_q[WIDTH-1]};
      ovf_d = ovf_q | acc_adj[AccW-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      op_q  <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign BCD_code = acc_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_b2bcd_seq_ctrl.sv
// Directed bench for b2bcd_seq_ctrl with three parameterisations side by side.
module tb_b2bcd_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // a: WIDTH=8 DIGIT=3, b: WIDTH=8 DIGIT=2, c: WIDTH=16 DIGIT=5
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf, a_busy;
  logic [7:0]  a_bin;
  logic [11:0] a_bcd;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf, b_busy;
  logic [7:0]  b_bin;
  logic [7:0]  b_bcd;
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_ovf, c_busy;
  logic [15:0] c_bin;
  logic [19:0] c_bcd;

  b2bcd_seq_ctrl #(.WIDTH(8), .DIGIT(3)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .Binary_code(a_bin), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .BCD_code(a_bcd), .overflow(a_ovf), .busy(a_busy)
  );

  b2bcd_seq_ctrl #(.WIDTH(8), .DIGIT(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .Binary_code(b_bin), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .BCD_code(b_bcd), .overflow(b_ovf), .busy(b_busy)
  );

  b2bcd_seq_ctrl #(.WIDTH(16), .DIGIT(5)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .Binary_code(c_bin), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .BCD_code(c_bcd), .overflow(c_ovf), .busy(c_busy)
  );

  // Present v for one edge, then count edges until out_valid; returns on that negedge.
  task automatic a_run(input logic [7:0] v, output int lat, output int rdy_hi);
    @(negedge clk); a_bin = v; a_in_valid = 1'b1;
    @(negedge clk); a_in_valid = 1'b0;
    lat = 0; rdy_hi = 0;
    while (lat < 40) begin
      if (a_in_ready) rdy_hi++;
      @(negedge clk); lat++;
      if (a_out_valid) break;
    end
  endtask

  task automatic b_run(input logic [7:0] v, output int lat);
    @(negedge clk); b_bin = v; b_in_valid = 1'b1;
    @(negedge clk); b_in_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk); lat++;
      if (b_out_valid) break;
    end
  endtask

  task automatic c_run(input logic [15:0] v, output int lat);
    @(negedge clk); c_bin = v; c_in_valid = 1'b1;
    @(negedge clk); c_in_valid = 1'b0;
    lat = 0;
    while (lat < 60) begin
      @(negedge clk); lat++;
      if (c_out_valid) break;
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", a_in_ready); end
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", a_out_valid); end
    n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", a_busy); end
    n_tests++; if (a_bcd !== 12'h000) begin n_fail++; $display("FAIL rst_bcd: got %h expected 000", a_bcd); end
    n_tests++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b expected 0", a_ovf); end
    n_tests++; if (c_bcd !== 20'h00000 || c_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wide: got bcd %h valid %b expected 00000/0", c_bcd, c_out_valid); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_latency_255();
    int lat, rh;
    a_out_ready = 1'b1;
    a_run(8'd255, lat, rh);
    n_tests++; if (lat != 8) begin n_fail++; $display("FAIL lat255_latency: got %0d expected 8", lat); end
    n_tests++; if (rh != 0) begin n_fail++; $display("FAIL lat255_in_ready_low: got %0d high cycles expected 0", rh); end
    n_tests++; if (a_bcd !== 12'h255) begin n_fail++; $display("FAIL lat255_bcd: got %h expected 255", a_bcd); end
    n_tests++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL lat255_ovf: got %b expected 0", a_ovf); end
    n_tests++; if (a_busy !== 1'b0 || a_in_ready !== 1'b0) begin n_fail++; $display("FAIL lat255_done_flags: got busy %b in_ready %b expected 0/0", a_busy, a_in_ready); end
    @(negedge clk);
    n_tests++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL lat255_to_idle: got out_valid %b in_ready %b expected 0/1", a_out_valid, a_in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  vin [3];
    logic [11:0] vexp [3];
    int lat, rh;
    vin[0] = 8'd0;   vexp[0] = 12'h000;
    vin[1] = 8'd9;   vexp[1] = 12'h009;
    vin[2] = 8'd100; vexp[2] = 12'h100;
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_run(vin[i], lat, rh);
      n_tests++; if (a_bcd !== vexp[i] || a_ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_bcd[%0d]: got %h/%b expected %h/0", i, a_bcd, a_ovf, vexp[i]); end
      n_tests++; if (lat != 8 || rh != 0) begin n_fail++; $display("FAIL b2b_timing[%0d]: got lat %0d ready-high %0d expected 8/0", i, lat, rh); end
    end
  endtask

  task automatic test_overflow();
    int lat;
    b_out_ready = 1'b1;
    b_run(8'd200, lat);
    n_tests++; if (b_bcd !== 8'h00 || b_ovf !== 1'b1 || lat != 8) begin n_fail++; $display("FAIL ovf_200: got %h/%b lat %0d expected 00/1 lat 8", b_bcd, b_ovf, lat); end
    b_run(8'd99, lat);
    n_tests++; if (b_bcd !== 8'h99 || b_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_99: got %h/%b expected 99/0", b_bcd, b_ovf); end
  endtask

  task automatic test_backpressure();
    int lat, rh, bad;
    a_out_ready = 1'b0;
    a_run(8'd42, lat, rh);
    n_tests++; if (a_bcd !== 12'h042 || a_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %h valid %b expected 042/1", a_bcd, a_out_valid); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin a_bin = 8'd7; a_in_valid = 1'b1; end
      if (i == 2) a_in_valid = 1'b0;
      if (a_out_valid !== 1'b1 || a_bcd !== 12'h042 || a_in_ready !== 1'b0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad cycles expected 0", bad); end
    a_out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin n_fail++; $display("FAIL bp_release: got valid %b ready %b busy %b expected 0/1/0", a_out_valid, a_in_ready, a_busy); end
  endtask

  task automatic test_reset_mid();
    int lat, rh, seen;
    a_out_ready = 1'b1;
    @(negedge clk); a_bin = 8'd173; a_in_valid = 1'b1;
    @(negedge clk); a_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++; if (a_in_ready !== 1'b1 || a_busy !== 1'b0 || a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got ready %b busy %b valid %b expected 1/0/0", a_in_ready, a_busy, a_out_valid); end
    n_tests++; if (a_bcd !== 12'h000 || a_ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_data: got %h/%b expected 000/0", a_bcd, a_ovf); end
    seen = 0;
    repeat (3) begin @(negedge clk); if (a_out_valid !== 1'b0) seen++; end
    rst = 1'b0;
    repeat (12) begin @(negedge clk); if (a_out_valid !== 1'b0 || a_busy !== 1'b0) seen++; end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_no_result: got %0d cycles active expected 0", seen); end
    a_run(8'd173, lat, rh);
    n_tests++; if (a_bcd !== 12'h173 || a_ovf !== 1'b0 || lat != 8) begin n_fail++; $display("FAIL rstmid_173: got %h/%b lat %0d expected 173/0 lat 8", a_bcd, a_ovf, lat); end
  endtask

  task automatic test_wide();
    int lat;
    c_out_ready = 1'b1;
    c_run(16'd65535, lat);
    n_tests++; if (c_bcd !== 20'h65535 || c_ovf !== 1'b0) begin n_fail++; $display("FAIL wide_bcd: got %h/%b expected 65535/0", c_bcd, c_ovf); end
    n_tests++; if (lat != 16) begin n_fail++; $display("FAIL wide_latency: got %0d expected 16", lat); end
  endtask

  initial begin
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_bin = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_bin = '0;
    c_in_valid = 1'b0; c_out_ready = 1'b0; c_bin = '0;
    test_reset();
    test_latency_255();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
